// File: rtl/counter_sequencer_pkg.sv
// rtl/counter_sequencer_pkg.sv - shared FSM state codes and counter mode codes
//
// Purpose : constants shared by the counter sequencer block.
//   S_IDLE..S_REPORT : sequencer FSM state encodings
//   MODO_LOAD        : counter mode that performs a parallel load of D
//   MODO_IDLE        : counter mode driven while the counter is parked
// Ports   : none (package)
package counter_sequencer_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [1:0] MODO_LOAD = 2'b11;
  localparam logic [1:0] MODO_IDLE = 2'b00;

endpackage

// File: rtl/counter_sequencer_rr_arbiter2.sv
// rtl/counter_sequencer_rr_arbiter2.sv - two-way round-robin arbiter with pointer
//
// Purpose : grants one of two requesters. When both request, the pointer
//           decides; a lone requester always wins. On an advance strobe the
//           pointer moves to the requester that was not granted.
// Ports   :
//   clk      in  1  clock, rising edge
//   reset_L  in  1  asynchronous active-low reset (pointer favours requester 0)
//   req      in  2  request bits
//   advance  in  1  a grant is being taken this cycle
//   grant    out 2  one-hot grant (combinational)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= 1'b0;
    end else if (advance) begin
      // granted requester 0 -> favour 1 next time, and vice versa
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - job sequencer and arbiter in front of a mode-programmable counter
//
// Purpose : accepts jobs (start value, count mode, run length) from two
//           requesters round-robin, drives the counter through one load
//           cycle and len count cycles, then returns final Q and a sticky
//           RCO flag on a valid/ready result port. Jobs with modo==2'b11
//           are rejected with done_err and never touch the counter.
// Options : RCO_ABORT_EN - when defined, cnt_RCO during RUN ends the job early.
// Ports   :
//   clk, reset_L                     clock / asynchronous active-low reset
//   req_valid[1:0], req_ready[1:0]   job handshake (ready one-hot, only in IDLE)
//   req_D, req_modo, req_len         per-requester job fields, requester i in slice i
//   cnt_enb, cnt_modo, cnt_D         registered counter controls
//   cnt_Q, cnt_RCO                   counter outputs
//   done_valid, done_ready           result handshake
//   done_id, done_Q, done_rco, done_err   registered result fields
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int W     = 16,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*W-1:0]     req_D,
  input  logic [3:0]         req_modo,
  input  logic [2*LEN_W-1:0] req_len,
  output logic               cnt_enb,
  output logic [1:0]         cnt_modo,
  output logic [W-1:0]       cnt_D,
  input  logic [W-1:0]       cnt_Q,
  input  logic               cnt_RCO,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               done_id,
  output logic [W-1:0]       done_Q,
  output logic               done_rco,
  output logic               done_err
);

  logic [1:0]       state;
  logic [1:0]       grant;
  logic             take;
  logic             gid;
  logic [W-1:0]     sel_d;
  logic [1:0]       sel_modo;
  logic [LEN_W-1:0] sel_len;

  logic             job_id;
  logic             job_err;
  logic [1:0]       job_modo;
  logic [LEN_W-1:0] run_cnt;
  logic             rco_flag;
  logic             run_end;

  assign take      = (state == S_IDLE) && (req_valid != 2'b00);
  assign req_ready = (state == S_IDLE) ? grant : 2'b00;
  assign gid       = grant[1];

  assign sel_d    = gid ? req_D[2*W-1:W]         : req_D[W-1:0];
  assign sel_modo = gid ? req_modo[3:2]          : req_modo[1:0];
  assign sel_len  = gid ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

`ifdef RCO_ABORT_EN
  assign run_end = (run_cnt == LEN_W'(1)) || cnt_RCO;
`else
  assign run_end = (run_cnt == LEN_W'(1));
`endif

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_L (reset_L),
    .req     (req_valid),
    .advance (take),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= S_IDLE;
      cnt_enb    <= 1'b0;
      cnt_modo   <= MODO_IDLE;
      cnt_D      <= '0;
      job_id     <= 1'b0;
      job_err    <= 1'b0;
      job_modo   <= MODO_IDLE;
      run_cnt    <= '0;
      rco_flag   <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= 1'b0;
      done_Q     <= '0;
      done_rco   <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            job_id   <= gid;
            job_modo <= sel_modo;
            run_cnt  <= sel_len;
            rco_flag <= 1'b0;
            if (sel_modo == MODO_LOAD) begin
              job_err <= 1'b1;
              state   <= S_REPORT;
            end else begin
              // controls are registered, so they are set here to be
              // visible to the counter during the LOAD cycle
              job_err  <= 1'b0;
              state    <= S_LOAD;
              cnt_enb  <= 1'b1;
              cnt_modo <= MODO_LOAD;
              cnt_D    <= sel_d;
            end
          end
        end
        S_LOAD: begin
          if (run_cnt == '0) begin
            state    <= S_REPORT;
            cnt_enb  <= 1'b0;
            cnt_modo <= MODO_IDLE;
          end else begin
            state    <= S_RUN;
            cnt_modo <= job_modo;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt - LEN_W'(1);
          if (cnt_RCO) begin
            rco_flag <= 1'b1;
          end
          if (run_end) begin
            state    <= S_REPORT;
            cnt_enb  <= 1'b0;
            cnt_modo <= MODO_IDLE;
          end
        end
        S_REPORT: begin
          // the counter applies its last step on the edge that enters
          // REPORT, so Q is sampled during the first REPORT cycle
          if (!done_valid) begin
            done_valid <= 1'b1;
            done_id    <= job_id;
            done_Q     <= job_err ? '0 : cnt_Q;
            done_rco   <= rco_flag;
            done_err   <= job_err;
          end else if (done_ready) begin
            done_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
